// File: rtl/rs_chien_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | rs_chien_ctrl_pkg : GF(2^8) types, tables and Chien-search constants     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package rs_chien_ctrl_pkg;

  localparam int SYMB_WIDTH      = 8;
  localparam int FIELD_POLY      = 285;
  localparam int T_LEN           = 8;
  localparam int ROOTS_PER_CYCLE = 16;
  localparam int ROOTS_NUM       = 254;

  localparam int FIELD_ORDER = (1 << SYMB_WIDTH) - 1;
  localparam int CYCLES_NUM  = (ROOTS_NUM + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
  localparam int NON_VALID   = ROOTS_NUM % ROOTS_PER_CYCLE;
  localparam int CNT_W       = $clog2(CYCLES_NUM);
  localparam int DEG_W       = $clog2(T_LEN + 1);
  localparam int ROOTS_W     = $clog2(ROOTS_NUM + 1);
  localparam int POPC_W      = $clog2(ROOTS_PER_CYCLE + 1);
  localparam int TAB_IDX_W   = $clog2(FIELD_ORDER);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [T_LEN:0] poly_t;
  typedef symb_t [FIELD_ORDER-1:0] alpha_tab_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } chien_state_t;

  localparam symb_t POLY_LOW = SYMB_WIDTH'(FIELD_POLY);

  function automatic symb_t gf_xtime(symb_t a);
    return a[SYMB_WIDTH-1] ? ((a << 1) ^ POLY_LOW) : (a << 1);
  endfunction

  function automatic symb_t gf_mul(symb_t a, symb_t b);
    symb_t p;
    symb_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  function automatic alpha_tab_t gen_alpha_tab();
    alpha_tab_t tab;
    symb_t      v;
    v = symb_t'(1);
    for (int k = 0; k < FIELD_ORDER; k++) begin
      tab[k] = v;
      v      = gf_xtime(v);
    end
    return tab;
  endfunction

  // ALPHA_TAB[k] = alpha^k, k = 0..FIELD_ORDER-1
  localparam alpha_tab_t ALPHA_TAB = gen_alpha_tab();

  function automatic logic [POPC_W-1:0] popcount(logic [ROOTS_PER_CYCLE-1:0] v);
    logic [POPC_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) n = n + POPC_W'(v[i]);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_chien_eval.sv
// +--------------------------------------------------------------------------+
// | rs_chien_eval : combinational Horner evaluation of lambda over one beat  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rs_chien_eval
  import rs_chien_ctrl_pkg::*;
(
  input  poly_t                      lambda_i,
  input  logic [CNT_W-1:0]           cnt_i,
  output logic [ROOTS_PER_CYCLE-1:0] zero_o
);

  localparam int EXP_W = $clog2(CYCLES_NUM * ROOTS_PER_CYCLE + 1);

  for (genvar j = 0; j < ROOTS_PER_CYCLE; j++) begin : g_root
    logic [EXP_W-1:0]     exp_raw;
    logic [TAB_IDX_W-1:0] exp_mod;
    symb_t                x;
    symb_t                acc;

    // Exponents past the field order wrap; they only occur in masked lanes.
    always_comb begin
      exp_raw = EXP_W'(cnt_i) * EXP_W'(ROOTS_PER_CYCLE) + EXP_W'(j + 1);
      exp_mod = (exp_raw >= EXP_W'(FIELD_ORDER)) ?
                TAB_IDX_W'(exp_raw - EXP_W'(FIELD_ORDER)) : TAB_IDX_W'(exp_raw);
      x       = ALPHA_TAB[exp_mod];
      acc     = lambda_i[T_LEN];
      for (int i = T_LEN - 1; i >= 0; i--) begin
        acc = gf_mul(acc, x) ^ lambda_i[i];
      end
    end

    assign zero_o[j] = (acc == '0);
  end

endmodule

`default_nettype wire

// File: rtl/rs_chien_ctrl.sv
// +--------------------------------------------------------------------------+
// | rs_chien_ctrl : Chien search sequencer, root-mask streaming and count    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rs_chien_ctrl
  import rs_chien_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lambda_vld,
  output logic                       lambda_rdy,
  input  poly_t                      lambda,
  input  logic [DEG_W-1:0]           lambda_deg,
  output logic                       err_pos_vld,
  input  logic                       err_pos_rdy,
  output logic [ROOTS_PER_CYCLE-1:0] err_pos,
  output logic [CNT_W-1:0]           err_pos_cnt,
  output logic                       err_pos_last,
  output logic [ROOTS_W-1:0]         roots_num,
  output logic                       fail
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_NUM - 1);
  localparam logic [ROOTS_PER_CYCLE-1:0] LAST_KEEP =
    (NON_VALID == 0) ? '1 : ROOTS_PER_CYCLE'((1 << NON_VALID) - 1);

  chien_state_t               state_q;
  poly_t                      lambda_q;
  logic [DEG_W-1:0]           deg_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [ROOTS_W-1:0]         acc_q;
  logic                       lambda_rdy_q;
  logic                       err_pos_vld_q;
  logic [ROOTS_PER_CYCLE-1:0] err_pos_q;
  logic [CNT_W-1:0]           err_pos_cnt_q;
  logic                       err_pos_last_q;
  logic [ROOTS_W-1:0]         roots_num_q;
  logic                       fail_q;

  logic [ROOTS_PER_CYCLE-1:0] zero_mask;
  logic [ROOTS_PER_CYCLE-1:0] mask_d;
  logic [ROOTS_W-1:0]         acc_d;
  logic                       fail_d;
  logic                       advance;

  rs_chien_eval u_eval (
    .lambda_i (lambda_q),
    .cnt_i    (cnt_q),
    .zero_o   (zero_mask)
  );

  // Lanes beyond ROOTS_NUM on the final beat (including alpha^0) are not candidates.
  always_comb begin
    mask_d  = zero_mask;
    if (cnt_q == LAST_CNT) mask_d = zero_mask & LAST_KEEP;
    acc_d   = acc_q + ROOTS_W'(popcount(mask_d));
    fail_d  = (acc_d != ROOTS_W'(deg_q)) || (deg_q > DEG_W'(T_LEN));
    advance = !err_pos_vld_q || err_pos_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      lambda_q       <= '0;
      deg_q          <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      lambda_rdy_q   <= 1'b0;
      err_pos_vld_q  <= 1'b0;
      err_pos_q      <= '0;
      err_pos_cnt_q  <= '0;
      err_pos_last_q <= 1'b0;
      roots_num_q    <= '0;
      fail_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          lambda_rdy_q <= 1'b1;
          if (lambda_vld && lambda_rdy_q) begin
            lambda_q     <= lambda;
            deg_q        <= lambda_deg;
            cnt_q        <= '0;
            acc_q        <= '0;
            lambda_rdy_q <= 1'b0;
            state_q      <= EVAL;
          end
        end
        EVAL: begin
          if (advance) begin
            err_pos_q     <= mask_d;
            err_pos_cnt_q <= cnt_q;
            err_pos_vld_q <= 1'b1;
            acc_q         <= acc_d;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              err_pos_last_q <= 1'b1;
              roots_num_q    <= acc_d;
              fail_q         <= fail_d;
              state_q        <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (err_pos_rdy) begin
            err_pos_vld_q  <= 1'b0;
            err_pos_last_q <= 1'b0;
            lambda_rdy_q   <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lambda_rdy   = lambda_rdy_q;
  assign err_pos_vld  = err_pos_vld_q;
  assign err_pos      = err_pos_q;
  assign err_pos_cnt  = err_pos_cnt_q;
  assign err_pos_last = err_pos_last_q;
  assign roots_num    = roots_num_q;
  assign fail         = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_chien_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_rs_chien_ctrl : directed self-checking bench for rs_chien_ctrl        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rs_chien_ctrl;
  import rs_chien_ctrl_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       lambda_vld;
  logic                       lambda_rdy;
  poly_t                      lambda;
  logic [DEG_W-1:0]           lambda_deg;
  logic                       err_pos_vld;
  logic                       err_pos_rdy;
  logic [ROOTS_PER_CYCLE-1:0] err_pos;
  logic [CNT_W-1:0]           err_pos_cnt;
  logic                       err_pos_last;
  logic [ROOTS_W-1:0]         roots_num;
  logic                       fail;

  rs_chien_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .lambda_vld   (lambda_vld),
    .lambda_rdy   (lambda_rdy),
    .lambda       (lambda),
    .lambda_deg   (lambda_deg),
    .err_pos_vld  (err_pos_vld),
    .err_pos_rdy  (err_pos_rdy),
    .err_pos      (err_pos),
    .err_pos_cnt  (err_pos_cnt),
    .err_pos_last (err_pos_last),
    .roots_num    (roots_num),
    .fail         (fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  cnt;
    logic        last;
    logic [7:0]  roots;
    logic        fail;
    int          cyc;
  } beat_t;

  beat_t bq[$];
  int    hsq[$];
  int    cyc     = 0;
  int    n_last  = 0;
  int    n_stall = 0;
  int    n_cmp   = 0;
  int    n_err   = 0;
  bit    stall_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted beats, handshakes and stall cycles as seen on the ports.
  always @(negedge clk) begin
    if (!rst) begin
      if (lambda_vld && lambda_rdy) hsq.push_back(cyc);
      if (err_pos_vld && err_pos_rdy) begin
        bq.push_back('{err_pos, err_pos_cnt, err_pos_last, roots_num, fail, cyc});
        if (err_pos_last) n_last = n_last + 1;
      end
      if (err_pos_vld && !err_pos_rdy) n_stall = n_stall + 1;
    end
  end

  initial begin
    err_pos_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      err_pos_rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic poly_t mk_poly(input symb_t c0, input symb_t c1, input symb_t c2);
    poly_t p;
    p    = '0;
    p[0] = c0;
    p[1] = c1;
    p[2] = c2;
    return p;
  endfunction

  // Candidate k sits in beat (k-1)/16, bit (k-1)%16.
  function automatic logic [15:0] exp_mask(input int c, input int r0, input int r1);
    logic [15:0] m;
    m = '0;
    for (int j = 0; j < 16; j++) begin
      if ((c * 16 + j + 1) == r0 || (c * 16 + j + 1) == r1) m[j] = 1'b1;
    end
    return m;
  endfunction

  task automatic send(input poly_t lam, input logic [DEG_W-1:0] deg);
    int n;
    @(posedge clk);
    #2;
    lambda     = lam;
    lambda_deg = deg;
    lambda_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!lambda_rdy && n < 100);
    chk("lambda_rdy_wait", 32'(lambda_rdy), 32'd1);
    @(posedge clk);
    #2;
    lambda_vld = 1'b0;
  endtask

  task automatic wait_last(input int target, output int rdy_cyc);
    int n;
    n = 0;
    while (n_last < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("last_beat_seen", 32'(n_last >= target), 32'd1);
    n = 0;
    while (!lambda_rdy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("lambda_rdy_back", 32'(lambda_rdy), 32'd1);
    rdy_cyc = cyc;
  endtask

  task automatic check_beats(input string tag, input int base, input int r0, input int r1,
                             input int exp_roots, input bit exp_fail);
    beat_t bt;
    chk($sformatf("%s_nbeats", tag), 32'(bq.size() - base >= 16), 32'd1);
    for (int c = 0; c < 16; c++) begin
      if (base + c < bq.size()) begin
        bt = bq[base + c];
        chk($sformatf("%s_b%0d_cnt", tag, c), 32'(bt.cnt), 32'(c));
        chk($sformatf("%s_b%0d_mask", tag, c), 32'(bt.mask), 32'(exp_mask(c, r0, r1)));
        chk($sformatf("%s_b%0d_last", tag, c), 32'(bt.last), 32'(c == 15));
        if (c == 15) begin
          chk($sformatf("%s_roots", tag), 32'(bt.roots), 32'(exp_roots));
          chk($sformatf("%s_fail", tag), 32'(bt.fail), 32'(exp_fail));
        end
      end
    end
  endtask

  task automatic run_cw(input string tag, input poly_t lam, input logic [DEG_W-1:0] deg,
                        input int r0, input int r1, input int exp_roots, input bit exp_fail,
                        input bit stall);
    int b, h, s, l, hs, rdy_cyc;
    stall_mode = stall;
    b = bq.size();
    h = hsq.size();
    s = n_stall;
    l = n_last;
    send(lam, deg);
    wait_last(l + 1, rdy_cyc);
    stall_mode = 1'b0;
    chk($sformatf("%s_hs_seen", tag), 32'(hsq.size() > h), 32'd1);
    hs = (hsq.size() > h) ? hsq[h] : 0;
    check_beats(tag, b, r0, r1, exp_roots, exp_fail);
    chk($sformatf("%s_cycles", tag), 32'(rdy_cyc - hs), 32'(18 + n_stall - s));
    if (!stall && bq.size() > b)
      chk($sformatf("%s_first_beat_cyc", tag), 32'(bq[b].cyc - hs), 32'd2);
  endtask

  task automatic reset_mid(input string tag, input bit stall);
    int n, l;
    stall_mode = stall;
    l = n_last;
    send(mk_poly(8'h01, 8'h20, 8'h00), 4'd1);
    n = 0;
    while (!(err_pos_vld && err_pos_cnt == 4'd7) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("%s_beat7_seen", tag), 32'(err_pos_vld && err_pos_cnt == 4'd7), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk($sformatf("%s_vld", tag), 32'(err_pos_vld), 32'd0);
    chk($sformatf("%s_roots", tag), 32'(roots_num), 32'd0);
    chk($sformatf("%s_fail", tag), 32'(fail), 32'd0);
    chk($sformatf("%s_last", tag), 32'(err_pos_last), 32'd0);
    chk($sformatf("%s_rdy_in_rst", tag), 32'(lambda_rdy), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("%s_rdy_after", tag), 32'(lambda_rdy), 32'd1);
    chk($sformatf("%s_no_last", tag), 32'(n_last - l), 32'd0);
    stall_mode = 1'b0;
  endtask

  task automatic back_to_back();
    int b, h, l, n, rdy_cyc;
    b = bq.size();
    h = hsq.size();
    l = n_last;
    @(posedge clk);
    #2;
    lambda     = mk_poly(8'h01, 8'h06, 8'h08);
    lambda_deg = 4'd2;
    lambda_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!lambda_rdy && n < 100);
    @(posedge clk);
    #2;
    lambda     = mk_poly(8'h01, 8'h20, 8'h00);
    lambda_deg = 4'd1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!lambda_rdy && n < 100);
    @(posedge clk);
    #2;
    lambda_vld = 1'b0;
    wait_last(l + 2, rdy_cyc);
    chk("b2b_hs_count", 32'(hsq.size() - h), 32'd2);
    if (hsq.size() >= h + 2) begin
      chk("b2b_hs2_cyc", 32'(hsq[h + 1] - hsq[h]), 32'd18);
      if (bq.size() > b + 16)
        chk("b2b_beat2_cyc", 32'(bq[b + 16].cyc - hsq[h]), 32'd20);
    end
    check_beats("b2b_cw1", b, 253, 254, 2, 1'b0);
    check_beats("b2b_cw2", b + 16, 250, -1, 1, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    lambda_vld = 1'b0;
    lambda     = '0;
    lambda_deg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_lambda_rdy", 32'(lambda_rdy), 32'd0);
    chk("rst_vld", 32'(err_pos_vld), 32'd0);
    chk("rst_err_pos", 32'(err_pos), 32'd0);
    chk("rst_cnt", 32'(err_pos_cnt), 32'd0);
    chk("rst_last", 32'(err_pos_last), 32'd0);
    chk("rst_roots", 32'(roots_num), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_lambda_rdy_after", 32'(lambda_rdy), 32'd1);

    // 1 + a^5 x -> root a^250; (1+a x)(1+a^2 x) = 1 + 06x + 08x^2 -> a^254, a^253
    run_cw("one_root", mk_poly(8'h01, 8'h20, 8'h00), 4'd1, 250, -1, 1, 1'b0, 1'b0);
    run_cw("two_root", mk_poly(8'h01, 8'h06, 8'h08), 4'd2, 253, 254, 2, 1'b0, 1'b0);
    run_cw("alpha0",   mk_poly(8'h01, 8'h01, 8'h00), 4'd1, -1, -1, 0, 1'b1, 1'b0);
    run_cw("deg9",     mk_poly(8'h01, 8'h20, 8'h00), 4'd9, 250, -1, 1, 1'b1, 1'b0);
    run_cw("deg0",     mk_poly(8'h01, 8'h00, 8'h00), 4'd0, -1, -1, 0, 1'b0, 1'b0);
    run_cw("bp_one",   mk_poly(8'h01, 8'h20, 8'h00), 4'd1, 250, -1, 1, 1'b0, 1'b1);
    run_cw("bp_two",   mk_poly(8'h01, 8'h06, 8'h08), 4'd2, 253, 254, 2, 1'b0, 1'b1);
    back_to_back();

    run_cw("pre_rst_a", mk_poly(8'h01, 8'h20, 8'h00), 4'd9, 250, -1, 1, 1'b1, 1'b0);
    reset_mid("rst_nostall", 1'b0);
    run_cw("post_rst_a", mk_poly(8'h01, 8'h20, 8'h00), 4'd1, 250, -1, 1, 1'b0, 1'b0);

    run_cw("pre_rst_b", mk_poly(8'h01, 8'h20, 8'h00), 4'd9, 250, -1, 1, 1'b1, 1'b0);
    reset_mid("rst_stall", 1'b1);
    run_cw("post_rst_b", mk_poly(8'h01, 8'h06, 8'h08), 4'd2, 253, 254, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
